// File: rtl/desc_feeder_pkg.sv
// Shared types and constants for the image-side descriptor feeder.
// Record layout is {row, col, descriptor[383:0]}; DESC_FEEDER_PAD_EN selects the padded build.
package desc_feeder_pkg;

  localparam int DESC_W    = 403;
  localparam int DESCR_W   = 384;
  localparam int COL_W     = 9;
  localparam int ROW_W     = 10;
  localparam int DESCR_LSB = 0;
  localparam int COL_LSB   = DESCR_LSB + DESCR_W;
  localparam int ROW_LSB   = COL_LSB + COL_W;

  localparam int IDX_W     = 12;
  localparam int CNT_W     = 11;
  localparam int GRP_W     = 9;
  localparam int MAX_GROUPS = 511;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_REQ,
    ST_FETCH,
    ST_DRAIN,
    ST_VALID,
    ST_EXHAUSTED
  } feeder_state_e;

  function automatic logic [DESC_W-1:0] make_record(
    input logic [ROW_W-1:0]   row,
    input logic [COL_W-1:0]   col,
    input logic [DESCR_W-1:0] descr
  );
    logic [DESC_W-1:0] r;
    r = '0;
    r[ROW_LSB +: ROW_W]     = row;
    r[COL_LSB +: COL_W]     = col;
    r[DESCR_LSB +: DESCR_W] = descr;
    return r;
  endfunction

  // All-ones descriptor sits at maximum distance, so a pad slot never wins a match.
  localparam logic [DESC_W-1:0] PAD_RECORD = make_record('0, '0, '1);

endpackage

// File: rtl/desc_addr_map.sv
// Maps a logical record index of the concatenated layer-1/layer-2 list to an SRAM address.
module desc_addr_map
  import desc_feeder_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int L1_BASE = 0,
  parameter int L2_BASE = 2048
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic [CNT_W-1:0]  layer1_num,
  output logic [ADDR_W-1:0] addr
);

  logic [IDX_W-1:0] off;

  always_comb begin
    off  = '0;
    addr = '0;
    if (idx < IDX_W'(layer1_num)) begin
      addr = ADDR_W'(L1_BASE) + ADDR_W'(idx);
    end else begin
      off  = idx - IDX_W'(layer1_num);
      addr = ADDR_W'(L2_BASE) + ADDR_W'(off);
    end
  end

endmodule

// File: rtl/descriptor_feeder.sv
// Fetches groups of four image descriptor records from SRAM on matcher request.
// Define DESC_FEEDER_PAD_EN to round the group count up and pad the final partial group.
module descriptor_feeder #(
  parameter int DESC_W  = 403,
  parameter int ADDR_W  = 12,
  parameter int L1_BASE = 0,
  parameter int L2_BASE = 2048
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [10:0]                    layer1_num,
  input  logic [10:0]                    layer2_num,
  input  logic                           descriptor_request,
  output logic                           descriptor_valid,
  output logic [DESC_W-1:0]              image_R_C_D_0,
  output logic [DESC_W-1:0]              image_R_C_D_1,
  output logic [DESC_W-1:0]              image_R_C_D_2,
  output logic [DESC_W-1:0]              image_R_C_D_3,
  output logic [8:0]                     img_group_num,
  output logic                           all_sent,
  output logic                           cfg_err,
  output logic [ADDR_W-1:0]              desc_addr,
  output logic                           desc_re,
  input  logic [DESC_W-1:0]              desc_dout,
  output desc_feeder_pkg::feeder_state_e state_dbg
);
  import desc_feeder_pkg::*;

  // Handshake: descriptor_request is a level held by the matcher until it sees the
  // one-cycle descriptor_valid pulse; request is ignored in VALID and the cycle after.

  feeder_state_e     state, state_nxt;
  logic [1:0]        slot;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  fetch_idx;
  logic [GRP_W-1:0]  grp_cnt;
  logic [CNT_W-1:0]  l1_q;
  logic              after_valid;
  logic              cap_en;
  logic              cap_pad;
  logic [1:0]        cap_slot;
  logic              slot_real;
  logic [ADDR_W-1:0] map_addr;
  logic [DESC_W-1:0] rec_q [4];
  logic [IDX_W-1:0]  total;
  logic [CNT_W-1:0]  groups;
  logic              cfg_bad;
  logic              cfg_empty;
`ifdef DESC_FEEDER_PAD_EN
  logic [IDX_W-1:0]  total_q;
`endif

  assign state_dbg = state;

  always_comb begin
    total = IDX_W'(layer1_num) + IDX_W'(layer2_num);
`ifdef DESC_FEEDER_PAD_EN
    groups = CNT_W'((13'(total) + 13'd3) >> 2);
`else
    groups = CNT_W'(total >> 2);
`endif
    cfg_bad   = (groups > CNT_W'(MAX_GROUPS));
    cfg_empty = (groups == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      state_nxt = ST_IDLE;
      ST_WAIT_REQ:  if (descriptor_request && !after_valid) state_nxt = ST_FETCH;
      ST_FETCH:     if (slot == 2'd3) state_nxt = ST_DRAIN;
      ST_DRAIN:     state_nxt = ST_VALID;
      ST_VALID:     state_nxt = (grp_cnt + 9'd1 == img_group_num) ? ST_EXHAUSTED : ST_WAIT_REQ;
      ST_EXHAUSTED: state_nxt = ST_EXHAUSTED;
      default:      state_nxt = ST_IDLE;
    endcase
    // A start in any state aborts the current fetch and re-evaluates the counts.
    if (start) begin
      if (cfg_bad)        state_nxt = ST_IDLE;
      else if (cfg_empty) state_nxt = ST_EXHAUSTED;
      else                state_nxt = ST_WAIT_REQ;
    end
  end

  always_comb begin
    fetch_idx = idx + IDX_W'(slot);
`ifdef DESC_FEEDER_PAD_EN
    slot_real = (fetch_idx < total_q);
`else
    slot_real = 1'b1;
`endif
    desc_re          = (state == ST_FETCH) && slot_real;
    desc_addr        = desc_re ? map_addr : '0;
    descriptor_valid = (state == ST_VALID);
    all_sent         = (state == ST_EXHAUSTED);
  end

  desc_addr_map #(
    .ADDR_W  (ADDR_W),
    .L1_BASE (L1_BASE),
    .L2_BASE (L2_BASE)
  ) u_addr_map (
    .idx        (fetch_idx),
    .layer1_num (l1_q),
    .addr       (map_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot          <= '0;
      idx           <= '0;
      grp_cnt       <= '0;
      l1_q          <= '0;
      img_group_num <= '0;
      cfg_err       <= 1'b0;
      after_valid   <= 1'b0;
`ifdef DESC_FEEDER_PAD_EN
      total_q       <= '0;
`endif
    end else if (start) begin
      slot          <= '0;
      idx           <= '0;
      grp_cnt       <= '0;
      l1_q          <= layer1_num;
      img_group_num <= (cfg_bad || cfg_empty) ? '0 : groups[GRP_W-1:0];
      cfg_err       <= cfg_bad;
      after_valid   <= 1'b0;
`ifdef DESC_FEEDER_PAD_EN
      total_q       <= total;
`endif
    end else begin
      slot        <= (state == ST_FETCH) ? slot + 2'd1 : 2'd0;
      after_valid <= (state == ST_VALID);
      if (state == ST_VALID) begin
        idx     <= idx + 12'd4;
        grp_cnt <= grp_cnt + 9'd1;
      end
    end
  end

  // Read data returns one cycle after its slot, so the slot tag is delayed to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en   <= 1'b0;
      cap_pad  <= 1'b0;
      cap_slot <= '0;
      for (int k = 0; k < 4; k++) rec_q[k] <= '0;
    end else begin
      cap_en   <= (state == ST_FETCH) && !start;
      cap_pad  <= !slot_real;
      cap_slot <= slot;
      if (cap_en && (state == ST_FETCH || state == ST_DRAIN)) begin
        rec_q[cap_slot] <= cap_pad ? DESC_W'(PAD_RECORD) : desc_dout;
      end
    end
  end

  assign image_R_C_D_0 = rec_q[0];
  assign image_R_C_D_1 = rec_q[1];
  assign image_R_C_D_2 = rec_q[2];
  assign image_R_C_D_3 = rec_q[3];

endmodule
